pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-requester arbiter that shares the single physical-memory port between the instruction cache and the data cache. Each cache issues whole-line (256-bit) reads, and the data cache also issues write-backs. The arbiter grants one line transaction at a time with round-robin fairness, then forwards the memory response to the granted cache only. It sits between the two cache instances and the burst/line adaptor or behavioural pmem model.

## Interface
- ADDR_WIDTH, 32, byte address width of every address port
- LINE_WIDTH, 256, cache-line data width of every data port

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- icache_addr  in  ADDR_WIDTH  line address from I-cache
- icache_read  in  1  I-cache line-read request
- icache_rdata  out  LINE_WIDTH  line returned to I-cache
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_addr  in  ADDR_WIDTH  line address from D-cache
- dcache_read  in  1  D-cache line-read request
- dcache_write  in  1  D-cache line write-back request
- dcache_wdata  in  LINE_WIDTH  write-back line
- dcache_rdata  out  LINE_WIDTH  line returned to D-cache
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- pmem_addr  out  ADDR_WIDTH  address to memory
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_wdata  out  LINE_WIDTH  write data to memory
- pmem_rdata  in  LINE_WIDTH  read data from memory
- pmem_resp  in  1  one-cycle completion pulse from memory

## Operation
- **Requester protocol.**
  - A requester raises read or write and holds it, with address and data stable, until the cycle after its resp.
  - dcache_read and dcache_write are never high together; the bench asserts this.
- **FSM states:** IDLE, SERVE_I, SERVE_D. A 1-bit `last` register records the last granted requester and resets to I, so D wins the first tie.
- **IDLE.**
  - No request pending: stay in IDLE.
  - Exactly one requester pending: go to that requester's SERVE state.
  - Both pending: go to SERVE of the requester not equal to `last`.
  - `last` is updated on entry to a SERVE state.
- **SERVE_x.**
  - pmem_addr, pmem_read, pmem_write and pmem_wdata are driven combinationally from the granted requester's inputs. I-cache never writes, so pmem_write = 0 in SERVE_I.
  - On pmem_resp, the granted requester's resp is driven high in the same cycle, and the next state is IDLE.
- **Outputs outside a grant.**
  - In IDLE, pmem_read, pmem_write, pmem_addr and pmem_wdata are all 0.
  - The non-granted requester's resp is always 0.
- **Read data.** icache_rdata and dcache_rdata both pass pmem_rdata through unconditionally. Requesters sample rdata only on their own resp.
- **Boundary conditions.**
  - pmem_resp while in IDLE is ignored: no resp is emitted and the state is unchanged.
  - A requester that drops its request mid-grant is a protocol violation. The arbiter keeps driving the captured grant's live inputs and stays in SERVE until pmem_resp.
  - A new request arriving during SERVE waits; it is evaluated in the following IDLE cycle.
  - Reset asserted mid-transaction: next state is IDLE, `last` is set to I, and all outputs are 0 the following cycle. The memory model is reset alongside.

## Timing
- **Reset values.** All outputs are 0 in the cycle after rst is sampled high; state is IDLE and `last` is I.
- **Grant latency.** A request is sampled in IDLE at edge N; pmem strobes assert in cycle N+1.
- **Response path.** Zero-cycle combinational pass-through from pmem_resp to xcache_resp, and from pmem_rdata to rdata.
- **Turnaround.**
  - After pmem_resp at cycle M, the state is IDLE at M+1, and the next grant's strobes appear at M+2.
  - Exactly one bubble cycle separates back-to-back transactions.
- **Strobe duration.** The pmem strobe stays high continuously from grant until and including the pmem_resp cycle, then is low for at least one cycle.
- **Throughput.** At most one outstanding memory transaction at any time.

## Test plan
- **Reset:**
  - stimulus: hold rst for 2 cycles with icache_read = 1;
  - required: all outputs 0 throughout; pmem_read rises 1 cycle after rst falls, with pmem_addr = icache_addr.
- **Single I read:**
  - stimulus: icache_addr = 0x0000_1000; memory responds after 5 cycles with rdata = 256'hA5…A5;
  - required: icache_resp pulses once, icache_rdata = 256'hA5…A5, dcache_resp stays 0.
- **D write-back:**
  - stimulus: dcache_write with addr = 0x8000_0040 and wdata = 256'h1234…;
  - required: pmem_write = 1, pmem_read = 0, pmem_wdata matches; dcache_resp pulses once on pmem_resp.
- **Simultaneous requests from reset:**
  - stimulus: icache_read and dcache_read both rise together;
  - required: D is served first, then I after the one-cycle bubble; grant order D, I.
- **Sustained contention:**
  - stimulus: both requesters reissue immediately after each resp, for 8 transactions;
  - required: grants strictly alternate (D, I, D, I, …), and neither requester waits more than one transaction.
- **Reset mid-transaction and stray response:**
  - stimulus: assert rst during SERVE_D before pmem_resp, then inject pmem_resp while IDLE;
  - required: strobes drop the cycle after rst; no resp is emitted for the stray pmem_resp; the next D request completes normally.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache.
// One line transaction at a time; the memory response is routed only to the granted cache.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic                  icache_read,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   i_req, d_req;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  // Read data is broadcast; each cache only samples it on its own resp.
  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    pmem_addr   = '0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_wdata  = '0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester not granted last time wins.
        if (i_req && d_req) begin
          if (last_q == LAST_I) begin
            state_d = SERVE_D;
            last_d  = LAST_D;
          end else begin
            state_d = SERVE_I;
            last_d  = LAST_I;
          end
        end else if (d_req) begin
          state_d = SERVE_D;
          last_d  = LAST_D;
        end else if (i_req) begin
          state_d = SERVE_I;
          last_d  = LAST_I;
        end
      end
      SERVE_I: begin
        pmem_addr   = icache_addr;
        pmem_read   = icache_read;
        icache_resp = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        pmem_addr   = dcache_addr;
        pmem_read   = dcache_read;
        pmem_write  = dcache_write;
        pmem_wdata  = dcache_wdata;
        dcache_resp = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: the bench itself plays both caches and the memory.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] icache_addr;
  logic          icache_read;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic [AW-1:0] dcache_addr;
  logic          dcache_read;
  logic          dcache_write;
  logic [LW-1:0] dcache_wdata;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic [AW-1:0] pmem_addr;
  logic          pmem_read;
  logic          pmem_write;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_cmp = 0;
  int n_err = 0;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_read(icache_read),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_addr(dcache_addr), .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    assert (!(dcache_read && dcache_write)) else $error("dcache read and write both high");

  // Advance to just after the next rising edge; inputs are then driven, outputs checked #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_read = 1'b1;
    icache_addr = 32'h0000_1000;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) begin
        n_err++; $display("FAIL reset_strobes: got %b want 0000", {pmem_read, pmem_write, icache_resp, dcache_resp});
      end
      n_cmp++;
      if (pmem_addr !== '0 || pmem_wdata !== '0 || icache_rdata !== '0 || dcache_rdata !== '0) begin
        n_err++; $display("FAIL reset_data: got addr %h wdata %h want 0", pmem_addr, pmem_wdata);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0) begin n_err++; $display("FAIL reset_release_same_cycle: got %b want 0", pmem_read); end
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_1000) begin
      n_err++; $display("FAIL reset_first_grant: got read %b addr %h want 1 00001000", pmem_read, pmem_addr);
    end
    pmem_resp = 1'b1;
    #1;
    tick();
    pmem_resp = 1'b0;
    icache_read = 1'b0;
  endtask

  task automatic test_single_i();
    logic [LW-1:0] a5 = {32{8'hA5}};
    int pulses = 0;
    icache_addr = 32'h0000_1000;
    icache_read = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h0000_1000) begin
      n_err++; $display("FAIL single_i_grant: got r%b w%b addr %h want r1 w0 00001000", pmem_read, pmem_write, pmem_addr);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (icache_resp) pulses++;
      n_cmp++;
      if (pmem_read !== 1'b1) begin n_err++; $display("FAIL single_i_hold: got %b want 1", pmem_read); end
    end
    pmem_resp = 1'b1;
    pmem_rdata = a5;
    #1;
    if (icache_resp) pulses++;
    n_cmp++;
    if (icache_resp !== 1'b1 || dcache_resp !== 1'b0) begin
      n_err++; $display("FAIL single_i_resp: got i%b d%b want i1 d0", icache_resp, dcache_resp);
    end
    n_cmp++;
    if (icache_rdata !== a5) begin n_err++; $display("FAIL single_i_rdata: got %h want %h", icache_rdata, a5); end
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    icache_read = 1'b0;
    #1;
    if (icache_resp) pulses++;
    n_cmp++;
    if (pulses !== 1 || pmem_read !== 1'b0) begin
      n_err++; $display("FAIL single_i_pulse: got pulses %0d read %b want 1 0", pulses, pmem_read);
    end
  endtask

  task automatic test_dwrite();
    logic [LW-1:0] wd = {8{32'h1234_5678}};
    dcache_addr = 32'h8000_0040;
    dcache_wdata = wd;
    dcache_write = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h8000_0040) begin
      n_err++; $display("FAIL dwrite_strobe: got w%b r%b addr %h want w1 r0 80000040", pmem_write, pmem_read, pmem_addr);
    end
    n_cmp++;
    if (pmem_wdata !== wd) begin n_err++; $display("FAIL dwrite_wdata: got %h want %h", pmem_wdata, wd); end
    tick();
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin
      n_err++; $display("FAIL dwrite_resp: got d%b i%b want d1 i0", dcache_resp, icache_resp);
    end
    tick();
    pmem_resp = 1'b0;
    dcache_write = 1'b0;
    #1;
    n_cmp++;
    if ({pmem_write, pmem_read, dcache_resp} !== 3'b0 || pmem_wdata !== '0) begin
      n_err++; $display("FAIL dwrite_idle: got w%b r%b d%b want 000", pmem_write, pmem_read, dcache_resp);
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    icache_addr = 32'h0000_2000;
    dcache_addr = 32'h0000_3000;
    icache_read = 1'b1;
    dcache_read = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_3000) begin
      n_err++; $display("FAIL simul_first_d: got r%b addr %h want r1 00003000", pmem_read, pmem_addr);
    end
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin
      n_err++; $display("FAIL simul_d_resp: got d%b i%b want d1 i0", dcache_resp, icache_resp);
    end
    tick();
    pmem_resp = 1'b0;
    dcache_read = 1'b0;
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0) begin n_err++; $display("FAIL simul_bubble: got %b want 0", pmem_read); end
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_2000) begin
      n_err++; $display("FAIL simul_second_i: got r%b addr %h want r1 00002000", pmem_read, pmem_addr);
    end
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (icache_resp !== 1'b1 || dcache_resp !== 1'b0) begin
      n_err++; $display("FAIL simul_i_resp: got i%b d%b want i1 d0", icache_resp, dcache_resp);
    end
    tick();
    pmem_resp = 1'b0;
    icache_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ia = 32'h0000_0100;
    logic [AW-1:0] da = 32'h0000_0200;
    logic          exp_d;
    icache_addr = ia;
    dcache_addr = da;
    icache_read = 1'b1;
    dcache_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      #1;
      n_cmp++;
      if (pmem_read !== 1'b1 || pmem_addr !== (exp_d ? da : ia)) begin
        n_err++; $display("FAIL b2b_grant[%0d]: got r%b addr %h want r1 %h", k, pmem_read, pmem_addr, exp_d ? da : ia);
      end
      pmem_resp = 1'b1;
      #1;
      n_cmp++;
      if (dcache_resp !== exp_d || icache_resp !== !exp_d) begin
        n_err++; $display("FAIL b2b_resp[%0d]: got d%b i%b want d%b i%b", k, dcache_resp, icache_resp, exp_d, !exp_d);
      end
      tick();
      pmem_resp = 1'b0;
      if (exp_d) begin da = da + 32'h40; dcache_addr = da; end
      else begin ia = ia + 32'h40; icache_addr = ia; end
      if (k == 7) begin icache_read = 1'b0; dcache_read = 1'b0; end
      #1;
      n_cmp++;
      if (pmem_read !== 1'b0) begin n_err++; $display("FAIL b2b_bubble[%0d]: got %b want 0", k, pmem_read); end
    end
  endtask

  task automatic test_reset_mid_and_stray();
    dcache_addr = 32'h0000_5000;
    dcache_read = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_5000) begin
      n_err++; $display("FAIL mid_grant: got r%b addr %h want r1 00005000", pmem_read, pmem_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dcache_read = 1'b0;
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_addr !== '0) begin
      n_err++; $display("FAIL mid_reset_drop: got r%b addr %h want r0 0", pmem_read, pmem_addr);
    end
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
      n_err++; $display("FAIL stray_resp: got i%b d%b want 0 0", icache_resp, dcache_resp);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0) begin n_err++; $display("FAIL stray_state: got r%b want 0", pmem_read); end
    // last was reset to I, so a tie must go to D again.
    icache_addr = 32'h0000_6000;
    dcache_addr = 32'h0000_7000;
    icache_read = 1'b1;
    dcache_read = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_7000) begin
      n_err++; $display("FAIL post_reset_d_grant: got r%b addr %h want r1 00007000", pmem_read, pmem_addr);
    end
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin
      n_err++; $display("FAIL post_reset_d_resp: got d%b i%b want d1 i0", dcache_resp, icache_resp);
    end
    tick();
    pmem_resp = 1'b0;
    dcache_read = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_6000) begin
      n_err++; $display("FAIL post_reset_i_grant: got r%b addr %h want r1 00006000", pmem_read, pmem_addr);
    end
    pmem_resp = 1'b1;
    #1;
    tick();
    pmem_resp = 1'b0;
    icache_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    icache_addr = '0;
    icache_read = 1'b0;
    dcache_addr = '0;
    dcache_read = 1'b0;
    dcache_write = 1'b0;
    dcache_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    test_reset();
    test_single_i();
    test_dwrite();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_and_stray();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
